// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the 2:1 AXI4 memory arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  localparam logic [3:0] ID_M0      = 4'd0;
  localparam logic [3:0] ID_M1      = 4'd1;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/arb_grant2.sv
// Two-request grant logic: fixed priority (req[1] wins) by default,
// alternating round-robin when ARB_ROUND_ROBIN_EN is defined.
module arb_grant2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant=1 means req[1] was served last, so req[0] wins a tie
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt = req;
    if (req[1]) gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// 2:1 AXI4 arbiter: M0 (fetch, read-only) and M1 (data, read+write) share one slave.
// Read arbitration is fixed-priority unless ARB_ROUND_ROBIN_EN is defined.
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_ar_valid,
  output logic            m0_ar_ready,
  input  logic [AW-1:0]   m0_ar_addr,
  input  logic [7:0]      m0_ar_len,
  output logic            m0_rd_valid,
  input  logic            m0_rd_ready,
  output logic [DW-1:0]   m0_rd_data,
  output logic            m0_rd_last,
  input  logic            m1_ar_valid,
  output logic            m1_ar_ready,
  input  logic [AW-1:0]   m1_ar_addr,
  input  logic [7:0]      m1_ar_len,
  output logic            m1_rd_valid,
  input  logic            m1_rd_ready,
  output logic [DW-1:0]   m1_rd_data,
  output logic            m1_rd_last,
  input  logic            m1_aw_valid,
  output logic            m1_aw_ready,
  input  logic [AW-1:0]   m1_aw_addr,
  input  logic [7:0]      m1_aw_len,
  input  logic            m1_wd_valid,
  output logic            m1_wd_ready,
  input  logic [DW-1:0]   m1_wd_data,
  input  logic [DW/8-1:0] m1_wd_strb,
  input  logic            m1_wd_last,
  output logic            m1_wr_valid,
  input  logic            m1_wr_ready,
  output logic            s_ar_valid,
  input  logic            s_ar_ready,
  output logic [3:0]      s_ar_id,
  output logic [7:0]      s_ar_len,
  output logic [AW-1:0]   s_ar_addr,
  output logic [2:0]      s_ar_size,
  output logic [1:0]      s_ar_burst,
  input  logic            s_rd_valid,
  output logic            s_rd_ready,
  input  logic [3:0]      s_rd_id,
  input  logic [DW-1:0]   s_rd_data,
  input  logic            s_rd_last,
  output logic            s_aw_valid,
  input  logic            s_aw_ready,
  output logic [3:0]      s_aw_id,
  output logic [7:0]      s_aw_len,
  output logic [AW-1:0]   s_aw_addr,
  output logic [2:0]      s_aw_size,
  output logic [1:0]      s_aw_burst,
  output logic            s_wd_valid,
  input  logic            s_wd_ready,
  output logic [DW-1:0]   s_wd_data,
  output logic [DW/8-1:0] s_wd_strb,
  output logic            s_wd_last,
  input  logic            s_wr_valid,
  output logic            s_wr_ready,
  input  logic [3:0]      s_wr_id
);

  rd_state_t     rd_state_reg;
  wr_state_t     wr_state_reg;
  logic          rd_m1_reg;
  logic          last_grant_reg;
  logic          m0_ar_ready_reg;
  logic          m1_ar_ready_reg;
  logic [3:0]    ar_id_reg;
  logic [AW-1:0] ar_addr_reg;
  logic [7:0]    ar_len_reg;
  logic          m1_aw_ready_reg;
  logic [3:0]    aw_id_reg;
  logic [AW-1:0] aw_addr_reg;
  logic [7:0]    aw_len_reg;
  logic [1:0]    rd_req;
  logic [1:0]    rd_gnt;
  logic          wr_idle;
  logic          rd_holds_m1;
  logic          rd_data_phase;
  logic          wr_data_phase;
  logic          wr_resp_phase;
  logic          unused_wr_id;

  assign wr_idle       = (wr_state_reg == W_IDLE);
  assign rd_holds_m1   = (rd_state_reg != R_IDLE) && rd_m1_reg;
  assign rd_data_phase = (rd_state_reg == R_DATA);
  assign wr_data_phase = (wr_state_reg == W_DATA);
  assign wr_resp_phase = (wr_state_reg == W_RESP);
  assign unused_wr_id  = ^s_wr_id;

  // An M1 read waits for the write side to be idle, and yields to a same-cycle write
  assign rd_req = {m1_ar_valid && wr_idle && !m1_aw_valid, m0_ar_valid};

  arb_grant2 u_grant (
    .req        (rd_req),
    .last_grant (last_grant_reg),
    .gnt        (rd_gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_reg    <= R_IDLE;
      rd_m1_reg       <= 1'b0;
      last_grant_reg  <= 1'b0;
      m0_ar_ready_reg <= 1'b0;
      m1_ar_ready_reg <= 1'b0;
      ar_id_reg       <= 4'd0;
      ar_addr_reg     <= '0;
      ar_len_reg      <= 8'd0;
    end else begin
      m0_ar_ready_reg <= 1'b0;
      m1_ar_ready_reg <= 1'b0;
      case (rd_state_reg)
        R_IDLE: begin
          if (|rd_gnt) begin
            rd_m1_reg       <= rd_gnt[1];
            last_grant_reg  <= rd_gnt[1];
            ar_id_reg       <= rd_gnt[1] ? ID_M1 : ID_M0;
            ar_addr_reg     <= rd_gnt[1] ? m1_ar_addr : m0_ar_addr;
            ar_len_reg      <= rd_gnt[1] ? m1_ar_len : m0_ar_len;
            m0_ar_ready_reg <= rd_gnt[0];
            m1_ar_ready_reg <= rd_gnt[1];
            rd_state_reg    <= R_ADDR;
          end
        end
        R_ADDR: if (s_ar_ready) rd_state_reg <= R_DATA;
        R_DATA: if (s_rd_valid && s_rd_ready && s_rd_last) rd_state_reg <= R_IDLE;
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_reg    <= W_IDLE;
      m1_aw_ready_reg <= 1'b0;
      aw_id_reg       <= 4'd0;
      aw_addr_reg     <= '0;
      aw_len_reg      <= 8'd0;
    end else begin
      m1_aw_ready_reg <= 1'b0;
      case (wr_state_reg)
        W_IDLE: begin
          if (m1_aw_valid && !rd_holds_m1) begin
            m1_aw_ready_reg <= 1'b1;
            aw_id_reg       <= ID_M1;
            aw_addr_reg     <= m1_aw_addr;
            aw_len_reg      <= m1_aw_len;
            wr_state_reg    <= W_ADDR;
          end
        end
        W_ADDR: if (s_aw_ready) wr_state_reg <= W_DATA;
        W_DATA: if (m1_wd_valid && s_wd_ready && m1_wd_last) wr_state_reg <= W_RESP;
        W_RESP: if (s_wr_valid && m1_wr_ready) wr_state_reg <= W_IDLE;
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  assign m0_ar_ready = m0_ar_ready_reg;
  assign m1_ar_ready = m1_ar_ready_reg;
  assign s_ar_valid  = (rd_state_reg == R_ADDR);
  assign s_ar_id     = ar_id_reg;
  assign s_ar_len    = ar_len_reg;
  assign s_ar_addr   = ar_addr_reg;
  assign s_ar_size   = SIZE_4B;
  assign s_ar_burst  = BURST_INCR;

  // Read data is steered by the registered grant, never by s_rd_id
  assign m0_rd_valid = rd_data_phase && !rd_m1_reg && s_rd_valid;
  assign m1_rd_valid = rd_data_phase && rd_m1_reg && s_rd_valid;
  assign m0_rd_last  = rd_data_phase && !rd_m1_reg && s_rd_last;
  assign m1_rd_last  = rd_data_phase && rd_m1_reg && s_rd_last;
  assign m0_rd_data  = s_rd_data;
  assign m1_rd_data  = s_rd_data;
  assign s_rd_ready  = rd_data_phase && (rd_m1_reg ? m1_rd_ready : m0_rd_ready);

  assign m1_aw_ready = m1_aw_ready_reg;
  assign s_aw_valid  = (wr_state_reg == W_ADDR);
  assign s_aw_id     = aw_id_reg;
  assign s_aw_len    = aw_len_reg;
  assign s_aw_addr   = aw_addr_reg;
  assign s_aw_size   = SIZE_4B;
  assign s_aw_burst  = BURST_INCR;

  assign s_wd_valid  = wr_data_phase && m1_wd_valid;
  assign s_wd_data   = m1_wd_data;
  assign s_wd_strb   = m1_wd_strb;
  assign s_wd_last   = wr_data_phase && m1_wd_last;
  assign m1_wd_ready = wr_data_phase && s_wd_ready;
  assign m1_wr_valid = wr_resp_phase && s_wr_valid;
  assign s_wr_ready  = wr_resp_phase && m1_wr_ready;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rd_data_phase && s_rd_valid && s_rd_ready && (s_rd_id != ar_id_reg))
      $error("axi_mem_arbiter: s_rd_id %0d does not match granted id %0d", s_rd_id, ar_id_reg);
  end
`endif

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter (default fixed-priority build) with a behavioural slave.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_ar_valid, m0_ar_ready, m0_rd_valid, m0_rd_ready, m0_rd_last;
  logic [31:0] m0_ar_addr, m0_rd_data;
  logic [7:0]  m0_ar_len;
  logic        m1_ar_valid, m1_ar_ready, m1_rd_valid, m1_rd_ready, m1_rd_last;
  logic [31:0] m1_ar_addr, m1_rd_data;
  logic [7:0]  m1_ar_len;
  logic        m1_aw_valid, m1_aw_ready;
  logic [31:0] m1_aw_addr;
  logic [7:0]  m1_aw_len;
  logic        m1_wd_valid, m1_wd_ready, m1_wd_last;
  logic [31:0] m1_wd_data;
  logic [3:0]  m1_wd_strb;
  logic        m1_wr_valid, m1_wr_ready;
  logic        s_ar_valid, s_ar_ready;
  logic [3:0]  s_ar_id;
  logic [7:0]  s_ar_len;
  logic [31:0] s_ar_addr;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic        s_rd_valid, s_rd_ready, s_rd_last;
  logic [3:0]  s_rd_id;
  logic [31:0] s_rd_data;
  logic        s_aw_valid, s_aw_ready;
  logic [3:0]  s_aw_id;
  logic [7:0]  s_aw_len;
  logic [31:0] s_aw_addr;
  logic [2:0]  s_aw_size;
  logic [1:0]  s_aw_burst;
  logic        s_wd_valid, s_wd_ready, s_wd_last;
  logic [31:0] s_wd_data;
  logic [3:0]  s_wd_strb;
  logic        s_wr_valid, s_wr_ready;
  logic [3:0]  s_wr_id;

  axi_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len),
    .m0_rd_valid(m0_rd_valid), .m0_rd_ready(m0_rd_ready), .m0_rd_data(m0_rd_data), .m0_rd_last(m0_rd_last),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len),
    .m1_rd_valid(m1_rd_valid), .m1_rd_ready(m1_rd_ready), .m1_rd_data(m1_rd_data), .m1_rd_last(m1_rd_last),
    .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len),
    .m1_wd_valid(m1_wd_valid), .m1_wd_ready(m1_wd_ready), .m1_wd_data(m1_wd_data), .m1_wd_strb(m1_wd_strb),
    .m1_wd_last(m1_wd_last), .m1_wr_valid(m1_wr_valid), .m1_wr_ready(m1_wr_ready),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_len(s_ar_len),
    .s_ar_addr(s_ar_addr), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_id(s_rd_id), .s_rd_data(s_rd_data), .s_rd_last(s_rd_last),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_len(s_aw_len),
    .s_aw_addr(s_aw_addr), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_wd_valid(s_wd_valid), .s_wd_ready(s_wd_ready), .s_wd_data(s_wd_data), .s_wd_strb(s_wd_strb),
    .s_wd_last(s_wd_last), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_id(s_wr_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave storage and the bench's independent expectation of memory contents
  logic [31:0] smem    [64];
  logic [31:0] exp_mem [64];

  // Slave read side: inputs sampled on negedge, outputs driven just after posedge
  initial begin : slave_rd
    logic hs_ar, hs_rd;
    logic [31:0] a_addr;
    logic [7:0]  a_len, rlen, rcnt;
    logic [3:0]  a_id;
    logic [5:0]  rptr;
    s_ar_ready = 1'b1; s_rd_valid = 1'b0; s_rd_last = 1'b0; s_rd_id = 4'd0; s_rd_data = 32'd0;
    rlen = 8'd0; rcnt = 8'd0; rptr = 6'd0;
    forever begin
      @(negedge clk);
      hs_ar = s_ar_valid & s_ar_ready;
      hs_rd = s_rd_valid & s_rd_ready;
      a_addr = s_ar_addr; a_len = s_ar_len; a_id = s_ar_id;
      @(posedge clk); #1;
      if (!reset) begin
        s_rd_valid = 1'b0; s_rd_last = 1'b0;
        continue;
      end
      if (hs_rd) begin
        if (s_rd_last) begin
          s_rd_valid = 1'b0; s_rd_last = 1'b0;
        end else begin
          rptr = rptr + 6'd1; rcnt = rcnt + 8'd1;
          s_rd_data = smem[rptr]; s_rd_last = (rcnt == rlen);
        end
      end
      if (hs_ar) begin
        rptr = a_addr[7:2]; rlen = a_len; rcnt = 8'd0;
        s_rd_valid = 1'b1; s_rd_data = smem[rptr]; s_rd_last = (a_len == 8'd0); s_rd_id = a_id;
      end
    end
  end

  initial begin : slave_wr
    logic hs_aw, hs_wd, hs_wr, w_last;
    logic [31:0] a_addr, w_data;
    logic [3:0]  a_id, w_strb, wid;
    logic [5:0]  wptr;
    s_aw_ready = 1'b1; s_wd_ready = 1'b1; s_wr_valid = 1'b0; s_wr_id = 4'd0;
    wptr = 6'd0; wid = 4'd0;
    forever begin
      @(negedge clk);
      hs_aw = s_aw_valid & s_aw_ready;
      hs_wd = s_wd_valid & s_wd_ready;
      hs_wr = s_wr_valid & s_wr_ready;
      a_addr = s_aw_addr; a_id = s_aw_id;
      w_data = s_wd_data; w_strb = s_wd_strb; w_last = s_wd_last;
      @(posedge clk); #1;
      if (!reset) begin
        s_wr_valid = 1'b0;
        continue;
      end
      if (hs_wr) s_wr_valid = 1'b0;
      if (hs_aw) begin
        wptr = a_addr[7:2]; wid = a_id;
      end
      if (hs_wd) begin
        for (int i = 0; i < 4; i++)
          if (w_strb[i]) smem[wptr][8*i +: 8] = w_data[8*i +: 8];
        wptr = wptr + 6'd1;
        if (w_last) begin
          s_wr_valid = 1'b1; s_wr_id = wid;
        end
      end
    end
  end

  task automatic do_read(input bit m, input logic [31:0] addr, input logic [7:0] len,
                         input int stall_at, input string tag, output int rcyc, output int gcyc);
    int n, k;
    logic [5:0] idx;
    @(posedge clk); #1;
    if (m) begin
      m1_ar_valid = 1'b1; m1_ar_addr = addr; m1_ar_len = len; m1_rd_ready = 1'b1;
    end else begin
      m0_ar_valid = 1'b1; m0_ar_addr = addr; m0_ar_len = len; m0_rd_ready = 1'b1;
    end
    n = 0;
    @(negedge clk);
    rcyc = cyc;
    while (!(m ? m1_ar_ready : m0_ar_ready) && n < 50) begin
      @(negedge clk); n++;
    end
    gcyc = cyc;
    check({tag, " ar_ready"}, m ? m1_ar_ready : m0_ar_ready, 1);
    check({tag, " s_ar_valid"}, s_ar_valid, 1);
    check({tag, " s_ar_id"}, s_ar_id, m ? 4'd1 : 4'd0);
    check({tag, " s_ar_addr"}, s_ar_addr, addr);
    check({tag, " s_ar_len"}, s_ar_len, len);
    @(posedge clk); #1;
    if (m) m1_ar_valid = 1'b0; else m0_ar_valid = 1'b0;
    k = 0; n = 0;
    while (k <= int'(len) && n < 200) begin
      @(negedge clk); n++;
      if (m ? (m1_rd_valid && m1_rd_ready) : (m0_rd_valid && m0_rd_ready)) begin
        idx = addr[7:2] + 6'(k);
        check({tag, " rd_data"}, m ? m1_rd_data : m0_rd_data, exp_mem[idx]);
        check({tag, " rd_last"}, m ? m1_rd_last : m0_rd_last, (k == int'(len)));
        check({tag, " other rd_valid"}, m ? m0_rd_valid : m1_rd_valid, 0);
        if (k == stall_at) begin
          @(posedge clk); #1;
          if (m) m1_rd_ready = 1'b0; else m0_rd_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            check({tag, " stall s_rd_ready"}, s_rd_ready, 0);
            check({tag, " stall rd_valid held"}, m ? m1_rd_valid : m0_rd_valid, 1);
          end
          @(posedge clk); #1;
          if (m) m1_rd_ready = 1'b1; else m0_rd_ready = 1'b1;
        end
        k++;
      end
    end
    check({tag, " beats"}, k, int'(len) + 1);
    $display("txn %s: read m%0d addr=%h len=%0d beats=%0d req_cyc=%0d gnt_cyc=%0d",
             tag, m, addr, len, k, rcyc, gcyc);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0,
                          input string tag, output int wcyc);
    int n;
    logic [5:0] idx;
    @(posedge clk); #1;
    m1_aw_valid = 1'b1; m1_aw_addr = addr; m1_aw_len = len; m1_wr_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m1_aw_ready && n < 50) begin
      @(negedge clk); n++;
    end
    check({tag, " aw_ready"}, m1_aw_ready, 1);
    check({tag, " s_aw_valid"}, s_aw_valid, 1);
    check({tag, " s_aw_id"}, s_aw_id, 4'd1);
    check({tag, " s_aw_addr"}, s_aw_addr, addr);
    check({tag, " s_aw_size/burst"}, {s_aw_size, s_aw_burst}, {3'b010, 2'b01});
    @(posedge clk); #1;
    m1_aw_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int b = 0; b <= int'(len); b++) begin
      m1_wd_valid = 1'b1; m1_wd_data = d0 + b; m1_wd_strb = 4'hF; m1_wd_last = (b == int'(len));
      n = 0;
      @(negedge clk);
      while (!m1_wd_ready && n < 50) begin
        @(negedge clk); n++;
      end
      check({tag, " wd_ready"}, m1_wd_ready, 1);
      check({tag, " s_wd_data"}, s_wd_data, d0 + b);
      idx = addr[7:2] + 6'(b);
      exp_mem[idx] = d0 + b;
      @(posedge clk); #1;
    end
    m1_wd_valid = 1'b0; m1_wd_last = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m1_wr_valid && n < 50) begin
      @(negedge clk); n++;
    end
    wcyc = cyc;
    check({tag, " wr_valid"}, m1_wr_valid, 1);
    $display("txn %s: write m1 addr=%h len=%0d resp_cyc=%0d", tag, addr, len, wcyc);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rc, gc, rc1, gc1, wc, n, k;
    reset = 1'b0;
    m0_ar_valid = 0; m0_ar_addr = 0; m0_ar_len = 0; m0_rd_ready = 0;
    m1_ar_valid = 0; m1_ar_addr = 0; m1_ar_len = 0; m1_rd_ready = 0;
    m1_aw_valid = 0; m1_aw_addr = 0; m1_aw_len = 0;
    m1_wd_valid = 0; m1_wd_data = 0; m1_wd_strb = 0; m1_wd_last = 0; m1_wr_ready = 0;
    for (int i = 0; i < 64; i++) begin
      smem[i]    = 32'hA000_0000 + i;
      exp_mem[i] = 32'hA000_0000 | i;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset s_ar_valid", s_ar_valid, 0);
    check("reset s_aw_valid", s_aw_valid, 0);
    check("reset ar_readys", {m0_ar_ready, m1_ar_ready, m1_aw_ready}, 3'b000);
    check("reset ids", {s_ar_id, s_aw_id}, 8'h00);
    check("reset rd/wd readys", {s_rd_ready, m1_wd_ready, s_wr_ready}, 3'b000);
    reset = 1'b1;

    // 1: M0 alone, 4-beat burst, one cycle request-to-s_ar_valid
    do_read(0, 32'h8000_0000, 8'd3, -1, "t1", rc, gc);
    check("t1 grant latency", gc - rc, 1);

    // 2: simultaneous requests, fixed priority serves M1 then M0
    fork
      do_read(1, 32'h8000_0080, 8'd0, -1, "t2 m1", rc1, gc1);
      do_read(0, 32'h8000_0084, 8'd0, -1, "t2 m0", rc, gc);
    join
    check("t2 m1 latency", gc1 - rc1, 1);
    check("t2 m0 after m1", gc - gc1, 3);

    // 3: M1 read issued during write data phase waits for the write response
    fork
      do_write(32'h8000_0010, 8'd1, 32'hDEAD_0000, "t3 wr", wc);
      begin
        repeat (3) @(posedge clk);
        do_read(1, 32'h8000_0010, 8'd1, -1, "t3 rd", rc, gc);
      end
    join
    check("t3 read grant after wr resp", gc - wc, 2);

    // 4: M0 backpressure for 5 cycles after beat index 1
    do_read(0, 32'h8000_0040, 8'd3, 1, "t4", rc, gc);

    // 5: reset during beat 2 of an M0 burst
    @(posedge clk); #1;
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h8000_0020; m0_ar_len = 8'd3; m0_rd_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m0_ar_ready && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    m0_ar_valid = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 50) begin
      @(negedge clk); n++;
      if (m0_rd_valid && m0_rd_ready) k++;
    end
    check("t5 reached beat 2", k, 2);
    reset = 1'b0;
    #1;
    check("t5 rd_valids", {m0_rd_valid, m1_rd_valid}, 2'b00);
    check("t5 s valids", {s_ar_valid, s_aw_valid, s_wd_valid, m1_wr_valid}, 4'b0000);
    check("t5 readys", {s_rd_ready, m0_ar_ready, m1_ar_ready, m1_aw_ready}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_read(0, 32'h8000_0020, 8'd1, -1, "t5 fresh", rc, gc);
    check("t5 fresh latency", gc - rc, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
